// File: rtl/wheel_sensor_emulator.sv
// Two-sensor track-pedal waveform generator: emits N axle passes (P1,P2,P3 dwell, then a gap)
// in the requested direction, with abort and a completion pulse.
module wheel_sensor_emulator #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned GAP   = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] axles,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] axles_sent
);

    localparam int unsigned MaxHold = (DWELL > GAP) ? DWELL : GAP;
    localparam int unsigned CntW    = (MaxHold > 1) ? $clog2(MaxHold) : 1;
    localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL - 1);
    localparam logic [CntW-1:0] GapLoad   = CntW'(GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StP1,
        StP2,
        StP3,
        StGap
    } state_e;

    state_e           r_state, w_state_d;
    logic [CntW-1:0]  r_cnt, w_cnt_d;
    logic             r_dir, w_dir_d;
    logic [CNT_W-1:0] r_axles, w_axles_d;
    logic [CNT_W-1:0] r_sent, w_sent_d;
    logic             r_a, r_b, r_busy, r_done;
    logic             w_done_d;
    logic [1:0]       w_ab_d;

    // Next-state: the dwell counter reloads on every state entry and fires at zero.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_dir_d   = r_dir;
        w_axles_d = r_axles;
        w_sent_d  = r_sent;
        w_done_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start && !abort) begin
                    w_sent_d = '0;
                    if (axles != '0) begin
                        w_dir_d   = dir;
                        w_axles_d = axles;
                        w_state_d = StP1;
                        w_cnt_d   = DwellLoad;
                    end else begin
                        w_done_d = 1'b1;
                    end
                end
            end
            StP1, StP2, StP3, StGap: begin
                if (abort) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_d = r_cnt - CntW'(1);
                end else begin
                    unique case (r_state)
                        StP1: begin
                            w_state_d = StP2;
                            w_cnt_d   = DwellLoad;
                        end
                        StP2: begin
                            w_state_d = StP3;
                            w_cnt_d   = DwellLoad;
                        end
                        StP3: begin
                            w_state_d = StGap;
                            w_cnt_d   = GapLoad;
                            w_sent_d  = r_sent + CNT_W'(1);
                        end
                        default: begin
                            if (r_sent == r_axles) begin
                                w_state_d = StIdle;
                                w_cnt_d   = '0;
                                w_done_d  = 1'b1;
                            end else begin
                                w_state_d = StP1;
                                w_cnt_d   = DwellLoad;
                            end
                        end
                    endcase
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Sensor levels are decoded from the next state so they register together with it.
    always_comb begin
        w_ab_d = 2'b00;
        unique case (w_state_d)
            StP1:    w_ab_d = w_dir_d ? 2'b01 : 2'b10;
            StP2:    w_ab_d = 2'b11;
            StP3:    w_ab_d = w_dir_d ? 2'b10 : 2'b01;
            default: w_ab_d = 2'b00;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_axles <= '0;
            r_sent  <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_dir   <= w_dir_d;
            r_axles <= w_axles_d;
            r_sent  <= w_sent_d;
            r_a     <= w_ab_d[1];
            r_b     <= w_ab_d[0];
            r_busy  <= (w_state_d != StIdle);
            r_done  <= w_done_d;
        end
    end

    assign a          = r_a;
    assign b          = r_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign axles_sent = r_sent;

endmodule

// File: tb/tb_wheel_sensor_emulator.sv
// Bench for wheel_sensor_emulator: a queue-of-phases reference model plus a pass detector
// monitor, driven by directed scenarios followed by randomized bursts.
module tb_wheel_sensor_emulator;

    localparam int unsigned DWELL = 4;
    localparam int unsigned GAP   = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned AXLE  = 3 * DWELL + GAP;

    logic             Clk = 1'b0;
    logic             Reset, start, dir, abort;
    logic [CNT_W-1:0] axles;
    logic             a, b, busy, done;
    logic [CNT_W-1:0] axles_sent;

    wheel_sensor_emulator #(
        .DWELL(DWELL),
        .GAP  (GAP),
        .CNT_W(CNT_W)
    ) u_dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .dir       (dir),
        .axles     (axles),
        .abort     (abort),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .axles_sent(axles_sent)
    );

    always #5 Clk = ~Clk;

    // Model: one queue entry per remaining busy cycle, holding the levels and count shown then.
    logic [1:0] q_ab[$];
    int         q_sent[$];
    int         m_sent;
    logic       m_done;

    int   vectors;
    int   miscompares;
    logic [7:0] hist;
    int   n_a2b, n_b2a;

    function automatic logic [1:0] phase_ab(int ph, logic d);
        case (ph)
            1:       return d ? 2'b01 : 2'b10;
            2:       return 2'b11;
            3:       return d ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic build_burst(logic d, int n);
        for (int ax = 0; ax < n; ax++) begin
            for (int ph = 1; ph <= 3; ph++) begin
                for (int c = 0; c < int'(DWELL); c++) begin
                    q_ab.push_back(phase_ab(ph, d));
                    q_sent.push_back(ax);
                end
            end
            for (int c = 0; c < int'(GAP); c++) begin
                q_ab.push_back(2'b00);
                q_sent.push_back(ax + 1);
            end
        end
    endtask

    task automatic check(string tag, logic [CNT_W+3:0] obs, logic [CNT_W+3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(string tag);
        logic             pre_busy;
        logic [1:0]       exp_ab;
        logic [CNT_W+3:0] exp_v;
        pre_busy = (q_ab.size() != 0);
        @(posedge Clk);
        m_done = 1'b0;
        if (Reset) begin
            q_ab.delete();
            q_sent.delete();
            m_sent = 0;
        end else if (pre_busy) begin
            if (abort) begin
                q_ab.delete();
                q_sent.delete();
            end else begin
                void'(q_ab.pop_front());
                void'(q_sent.pop_front());
                if (q_ab.size() == 0) m_done = 1'b1;
                else m_sent = q_sent[0];
            end
        end else if (start && !abort) begin
            m_sent = 0;
            if (axles == '0) m_done = 1'b1;
            else build_burst(dir, int'(axles));
        end
        #1;
        exp_ab = (q_ab.size() != 0) ? q_ab[0] : 2'b00;
        exp_v  = {exp_ab, (q_ab.size() != 0), m_done, CNT_W'(m_sent)};
        check(tag, {a, b, busy, done, axles_sent}, exp_v);
        if ({a, b} != hist[1:0]) begin
            hist = {hist[5:0], a, b};
            if (hist == 8'b10_11_01_00) n_a2b++;
            if (hist == 8'b01_11_10_00) n_b2a++;
        end
    endtask

    task automatic issue(string tag, logic d, int n);
        start = 1'b1;
        dir   = d;
        axles = CNT_W'(n);
        tick(tag);
        start = 1'b0;
    endtask

    task automatic run_idle(string tag, int budget, int abort_pct, int start_pct);
        int left;
        left = budget;
        while (q_ab.size() != 0 && left > 0) begin
            abort = ($urandom_range(0, 99) < abort_pct);
            start = ($urandom_range(0, 99) < start_pct);
            dir   = 1'($urandom);
            axles = CNT_W'($urandom);
            tick(tag);
            left--;
        end
        abort = 1'b0;
        start = 1'b0;
        vectors++;
        if (left == 0) begin
            miscompares++;
            $display("FAIL %s_budget observed=busy expected=idle within %0d cycles", tag, budget);
        end
    endtask

    task automatic count_check(string tag, int obs, int exp);
        vectors++;
        assert (obs == exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_sent      = 0;
        m_done      = 1'b0;
        hist        = 8'h00;
        n_a2b       = 0;
        n_b2a       = 0;
        Reset       = 1'b1;
        start       = 1'b0;
        dir         = 1'b0;
        axles       = '0;
        abort       = 1'b0;
        tick("reset0");
        tick("reset1");
        Reset = 1'b0;
        tick("idle");

        // dir=1, three axles, quiet inputs
        issue("b2a3_accept", 1'b1, 3);
        run_idle("b2a3", 4 * AXLE, 0, 0);
        tick("b2a3_after");

        // Zero-count start
        issue("zero_start", 1'b0, 0);
        for (int i = 0; i < 3; i++) tick("zero_after");

        // Start pulsed during P2 is ignored
        issue("busy_start_accept", 1'b0, 2);
        for (int i = 0; i < int'(DWELL) + 1; i++) tick("busy_start_p1");
        issue("busy_start_pulse", 1'b1, 5);
        run_idle("busy_start", 3 * AXLE, 0, 0);

        // Abort in the 2nd cycle of P2 of axle 2, then restart
        issue("abort_accept", 1'b0, 3);
        for (int i = 0; i < int'(AXLE + DWELL + 1); i++) tick("abort_run");
        abort = 1'b1;
        tick("abort_edge");
        abort = 1'b0;
        tick("abort_idle");
        abort = 1'b1;
        issue("abort_with_start", 1'b1, 2);
        abort = 1'b0;
        issue("restart_accept", 1'b1, 1);
        run_idle("restart", 2 * AXLE, 0, 0);

        // Loopback: four a-to-b passes, then back-to-back four b-to-a passes
        hist  = 8'h00;
        n_a2b = 0;
        n_b2a = 0;
        issue("loop_a2b_accept", 1'b0, 4);
        run_idle("loop_a2b", 5 * AXLE, 0, 0);
        count_check("loop_a2b_count", n_a2b, 4);
        count_check("loop_a2b_mirror", n_b2a, 0);
        issue("loop_b2a_accept", 1'b1, 4);
        run_idle("loop_b2a", 5 * AXLE, 0, 0);
        count_check("loop_b2a_count", n_b2a, 4);
        count_check("loop_b2a_mirror", n_a2b, 4);

        // Randomized bursts with sporadic aborts and ignored starts
        for (int it = 0; it < 25; it++) begin
            issue("rand_accept", 1'($urandom), int'($urandom_range(0, 4)));
            run_idle("rand", 6 * AXLE, 1, 10);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick("rand_idle");
        end

        // Reset mid-burst has priority
        issue("reset_mid_accept", 1'b0, 2);
        for (int i = 0; i < 5; i++) tick("reset_mid_run");
        Reset = 1'b1;
        start = 1'b1;
        tick("reset_mid");
        Reset = 1'b0;
        start = 1'b0;
        tick("reset_mid_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
